lan_bus_master: RTL
===================

LAN_BUS_MASTER -- requirements
Module: lan_bus_master

Interface
REQ-001 Parameter SETUP_CYC, default 5, meaning cycles of address/data setup before the strobe; legal range 1..255.
REQ-002 Parameter STROBE_CYC, default 5, meaning cycles LanCs plus LanRd or LanWr are held low; legal range 1..255.
REQ-003 Parameter HOLD_CYC, default 5, meaning cycles of address/data hold after the strobe rises; legal range 1..255.
REQ-004 Port Clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-005 Port Rst  input  1  synchronous active-high reset.
REQ-006 Port ReqValid  input  1  the requester has an access pending.
REQ-007 Port ReqReady  output  1  the block can accept an access this cycle.
REQ-008 Port ReqWrite  input  1  1 = write access, 0 = read access.
REQ-009 Port ReqAddr  input  10  chip register address.
REQ-010 Port ReqWData  input  16  write data; ignored for reads.
REQ-011 Port RspValid  output  1  one-cycle pulse marking a completed access.
REQ-012 Port RspRData  output  16  read data; valid while RspValid=1 after a read.
REQ-013 Port LanAddr  output  10  chip address bus.
REQ-014 Port LanData  inout  16  chip data bus; tri-stated unless this block is writing.
REQ-015 Port LanCs / LanRd / LanWr  output  1 each  chip select, read strobe and write strobe; all active-low.

Function
REQ-016 The block SHALL implement the states IDLE, SETUP, STROBE and HOLD, driven by an 8-bit phase counter.
REQ-017 ReqReady SHALL be 1 only in IDLE and not in reset; an access is accepted on any edge where ReqValid=1 and ReqReady=1.
REQ-018 On acceptance, the block SHALL latch ReqWrite, ReqAddr and ReqWData, drive LanAddr from the latched address, and enter SETUP with the counter cleared.
REQ-019 In SETUP (SETUP_CYC cycles), LanCs, LanRd and LanWr SHALL all be 1.
REQ-020 In STROBE (STROBE_CYC cycles), LanCs SHALL be 0, and LanRd=0 for a read or LanWr=0 for a write, never both.
REQ-021 In HOLD (HOLD_CYC cycles), all strobes SHALL be 1 again.
REQ-022 LanAddr SHALL stay stable from SETUP through HOLD.
REQ-023 LanData SHALL be driven with the latched write data from the first SETUP cycle through the last HOLD cycle of a write; at all other times it is high-Z.
REQ-024 For a read, RspRData SHALL capture LanData on the edge that ends the final STROBE cycle.
REQ-025 When HOLD ends, the block SHALL return to IDLE and assert RspValid for exactly that first IDLE cycle.
REQ-026 Latency: RspValid SHALL be high exactly SETUP_CYC+STROBE_CYC+HOLD_CYC cycles after the accept edge (15 with defaults).
REQ-027 Back-to-back: an access SHALL be acceptable in the same cycle RspValid is high, giving one access per SETUP+STROBE+HOLD+1 cycles.
REQ-028 After a write, RspRData SHALL keep its previous value.
REQ-029 While not IDLE, ReqValid and the request inputs SHALL be ignored; there is no queueing.
REQ-030 Parameter value 1 SHALL give a single-cycle phase; the counter SHALL never wrap within a phase.

Reset
REQ-031 With Rst=1 at an edge, the block SHALL go to IDLE with LanCs=LanRd=LanWr=1, LanAddr=0, LanData high-Z, ReqReady=0, RspValid=0 and RspRData=0.
REQ-032 Reset mid-access SHALL take effect at the next edge: strobes deasserted, bus released, access dropped, and no RspValid pulse.
REQ-033 ReqReady SHALL rise on the first edge after Rst falls.

Verification
REQ-034 Write 0x08 <- 0xAABB (defaults) -> LanAddr=0x08 and LanData=0xAABB for 15 cycles; LanCs/LanWr low for cycles 6..10; LanRd stays 1; RspValid pulses at cycle 15.
REQ-035 Read 0xFE, bus model returns 0x5300 during the strobe -> LanRd/LanCs low for cycles 6..10; LanData high-Z; RspRData=0x5300 with RspValid at cycle 15.
REQ-036 ReqValid held high with three writes (0x14, 0x16, 0x18) -> three accesses 16 cycles apart; never both strobes low; RspValid count = 3.
REQ-037 Rst pulsed during STROBE of a write -> strobes high on the next edge; LanData high-Z; no RspValid; next read completes normally.
REQ-038 SETUP_CYC=STROBE_CYC=HOLD_CYC=1 read -> one-cycle strobe; RspValid exactly 3 cycles after accept.
REQ-039 ReqValid pulsed while in HOLD -> request ignored; ReqReady=0 during the pulse.

Source files
------------

// File: rtl/lan_bus_master_if.sv
// Request/response handshake between a requester and lan_bus_master.
// The block owns the master modport; the requester side uses slave.
interface lan_bus_master_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [9:0]  ReqAddr;
  logic [15:0] ReqWData;
  logic        RspValid;
  logic [15:0] RspRData;

  modport master (input ReqValid, ReqWrite, ReqAddr, ReqWData,
                  output ReqReady, RspValid, RspRData);
  modport slave  (output ReqValid, ReqWrite, ReqAddr, ReqWData,
                  input ReqReady, RspValid, RspRData);
endinterface

// File: rtl/lan_bus_master.sv
// Single-access master for an asynchronous LAN chip register bus.
// Each access runs SETUP -> STROBE -> HOLD with programmable phase lengths.
module lan_bus_master #(
  parameter int unsigned SETUP_CYC  = 5,
  parameter int unsigned STROBE_CYC = 5,
  parameter int unsigned HOLD_CYC   = 5
) (
  input  logic        Clk,
  input  logic        Rst,
  lan_bus_master_if.master req,
  output logic [9:0]  LanAddr,
  inout  wire  [15:0] LanData,
  output logic        LanCs,
  output logic        LanRd,
  output logic        LanWr
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);

  state_e      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        last, accept, wr_nxt;
  logic        wr_q, drv_q, rdy_q, rsp_q;
  logic [15:0] wdata_q, rdata_q;

  // Ready is registered, so it implies IDLE and stays low through reset.
  assign accept = rdy_q && req.ReqValid;
  assign wr_nxt = accept ? req.ReqWrite : wr_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 8'd1;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept) state_nxt = SETUP;
      end
      SETUP: begin
        last = (cnt == SETUP_LAST);
        if (last) state_nxt = STROBE;
      end
      STROBE: begin
        last = (cnt == STROBE_LAST);
        if (last) state_nxt = HOLD;
      end
      HOLD: begin
        last = (cnt == HOLD_LAST);
        if (last) state_nxt = IDLE;
      end
    endcase
    // Counter restarts at every phase boundary, so it never exceeds 254.
    if (last) cnt_nxt = '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdy_q   <= 1'b0;
      rsp_q   <= 1'b0;
      drv_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      LanAddr <= '0;
      LanCs   <= 1'b1;
      LanRd   <= 1'b1;
      LanWr   <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rdy_q <= (state_nxt == IDLE);
      rsp_q <= (state == HOLD) && last;
      if (accept) begin
        wr_q    <= req.ReqWrite;
        LanAddr <= req.ReqAddr;
        wdata_q <= req.ReqWData;
      end
      // Pins are registered from the next state to keep the strobes glitch-free.
      drv_q <= wr_nxt && (state_nxt != IDLE);
      LanCs <= (state_nxt != STROBE);
      LanRd <= !((state_nxt == STROBE) && !wr_nxt);
      LanWr <= !((state_nxt == STROBE) && wr_nxt);
      if ((state == STROBE) && last && !wr_q) rdata_q <= LanData;
    end
  end

  assign LanData      = drv_q ? wdata_q : 16'hzzzz;
  assign req.ReqReady = rdy_q;
  assign req.RspValid = rsp_q;
  assign req.RspRData = rdata_q;
endmodule
